sequence_detector_param: RTL and testbench

Parametrised serial bit-pattern detector, the next generation of the fixed 3-bit "110" detector in the finite-state-machine chapter. A runtime-loadable pattern of `LEN` bits is detected on a qualified serial input, in overlapping or non-overlapping mode. The block gives both an immediate (Mealy, may glitch) match and a registered glitch-free match, plus a saturating match counter. It sits between a serial bit source and status/interrupt logic.

---
 rtl/sequence_detector_param.sv | 82 ++++++++
 tb/tb_sequence_detector_param.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_detector_param.sv
// Serial pattern detector: runtime-loadable LEN-bit pattern on a qualified bit stream,
// overlapping or non-overlapping, with immediate and registered match plus a saturating counter.
module sequence_detector_param #(
  parameter int unsigned LEN   = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic             load,
  input  logic [LEN-1:0]   pattern,
  input  logic             cnt_clr,
  output logic             match_comb,
  output logic             match_reg,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  localparam int unsigned HIST_W = LEN - 1;
  localparam int unsigned FILL_W = $clog2(LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN - 1);

  logic [LEN-1:0]    pat_reg;
  logic [HIST_W-1:0] hist;
  logic [HIST_W-1:0] hist_nxt;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;
  logic [LEN-1:0]    cand;

  // Candidate window: stored history followed by the bit on the wire this cycle.
  assign cand       = {hist, x};
  assign armed      = (fill == FILL_FULL);
  assign match_comb = x_valid & ~load & armed & (cand == pat_reg);

  // Next-state for history and fill level; load restarts detection without touching hist.
  always_comb begin
    hist_nxt = hist;
    fill_nxt = fill;
    if (load) begin
      fill_nxt = '0;
    end else if (x_valid) begin
      hist_nxt = cand[HIST_W-1:0];
      if (match_comb && !overlap) begin
        fill_nxt = '0;
      end else if (fill != FILL_FULL) begin
        fill_nxt = fill + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_reg <= '0;
      hist    <= '0;
      fill    <= '0;
    end else begin
      if (load) begin
        pat_reg <= pattern;
      end
      hist <= hist_nxt;
      fill <= fill_nxt;
    end
  end

  // Registered match and saturating counter; clear wins over a same-cycle match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_reg   <= 1'b0;
      match_count <= '0;
    end else begin
      match_reg <= match_comb;
      if (cnt_clr) begin
        match_count <= '0;
      end else if (match_comb && !(&match_count)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sequence_detector_param.sv
// Bench for sequence_detector_param: three instances (LEN 3/4/2) share one stimulus stream and
// are compared every cycle against a queue-based model, plus directed vectors and sequences.
module tb_sequence_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, x, x_valid, overlap, load, cnt_clr;
  logic [2:0] pat3;
  logic [3:0] pat4;
  logic [1:0] pat2;
  logic       mc_a, mr_a, arm_a, mc_b, mr_b, arm_b, mc_c, mr_c, arm_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  sequence_detector_param #(.LEN(3), .CNT_W(8)) u_a (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .overlap(overlap), .load(load),
    .pattern(pat3), .cnt_clr(cnt_clr), .match_comb(mc_a), .match_reg(mr_a),
    .match_count(cnt_a), .armed(arm_a));

  sequence_detector_param #(.LEN(4), .CNT_W(8)) u_b (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .overlap(overlap), .load(load),
    .pattern(pat4), .cnt_clr(cnt_clr), .match_comb(mc_b), .match_reg(mr_b),
    .match_count(cnt_b), .armed(arm_b));

  sequence_detector_param #(.LEN(2), .CNT_W(2)) u_c (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .overlap(overlap), .load(load),
    .pattern(pat2), .cnt_clr(cnt_clr), .match_comb(mc_c), .match_reg(mr_c),
    .match_count(cnt_c), .armed(arm_c));

  int errors = 0;
  int checks = 0;

  // Model: accepted bits since the last restart, oldest first.
  bit          hq0[$];
  bit          hq1[$];
  bit          hq2[$];
  logic [31:0] mpat[3];
  int          mcnt[3];
  bit          mreg[3];
  int          lens[3] = '{3, 4, 2};
  int          cmax[3] = '{255, 255, 3};

  typedef struct {
    logic       ld, v, xb, clr;
    logic [2:0] p;
    logic       e_comb, e_reg;
    logic [7:0] e_cnt;
    logic       e_arm;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(input int ld, input int v, input int xb, input int clr, input int p,
                              input int ec, input int er, input int en, input int ea);
    vec_t r;
    r.ld = 1'(ld); r.v = 1'(v); r.xb = 1'(xb); r.clr = 1'(clr); r.p = 3'(p);
    r.e_comb = 1'(ec); r.e_reg = 1'(er); r.e_cnt = 8'(en); r.e_arm = 1'(ea);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hist_ok(input bit q[$], input int len, input logic [31:0] pat, input bit xb);
    if (q.size() < len - 1) return 1'b0;
    for (int i = 0; i < len - 1; i++)
      if (q[q.size() - (len - 1) + i] != pat[len - 1 - i]) return 1'b0;
    return xb == pat[0];
  endfunction

  function automatic bit exp_comb(input int k);
    bit q[$];
    case (k)
      0:       q = hq0;
      1:       q = hq1;
      default: q = hq2;
    endcase
    return (x_valid === 1'b1) && (load === 1'b0) && hist_ok(q, lens[k], mpat[k], x);
  endfunction

  function automatic int hist_size(input int k);
    case (k)
      0:       return hq0.size();
      1:       return hq1.size();
      default: return hq2.size();
    endcase
  endfunction

  task automatic model_reset();
    hq0.delete(); hq1.delete(); hq2.delete();
    for (int k = 0; k < 3; k++) begin
      mpat[k] = '0; mcnt[k] = 0; mreg[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit mc[3];
    bit restart, push;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) mc[k] = exp_comb(k);
    for (int k = 0; k < 3; k++) begin
      restart = load || (x_valid && mc[k] && !overlap);
      push    = !load && x_valid && !restart;
      case (k)
        0: begin if (restart) hq0.delete(); else if (push) hq0.push_back(x);
                 if (hq0.size() > 40) void'(hq0.pop_front()); end
        1: begin if (restart) hq1.delete(); else if (push) hq1.push_back(x);
                 if (hq1.size() > 40) void'(hq1.pop_front()); end
        default: begin if (restart) hq2.delete(); else if (push) hq2.push_back(x);
                 if (hq2.size() > 40) void'(hq2.pop_front()); end
      endcase
      if (cnt_clr) mcnt[k] = 0;
      else if (mc[k] && mcnt[k] < cmax[k]) mcnt[k]++;
      mreg[k] = mc[k];
    end
    if (load) begin
      mpat[0] = 32'(pat3); mpat[1] = 32'(pat4); mpat[2] = 32'(pat2);
    end
  endtask

  task automatic get_dut(input int k, output logic [31:0] c, output logic [31:0] r,
                         output logic [31:0] a, output logic [31:0] n);
    case (k)
      0:       begin c = 32'(mc_a); r = 32'(mr_a); a = 32'(arm_a); n = 32'(cnt_a); end
      1:       begin c = 32'(mc_b); r = 32'(mr_b); a = 32'(arm_b); n = 32'(cnt_b); end
      default: begin c = 32'(mc_c); r = 32'(mr_c); a = 32'(arm_c); n = 32'(cnt_c); end
    endcase
  endtask

  task automatic check_all();
    logic [31:0] c, r, a, n;
    for (int k = 0; k < 3; k++) begin
      get_dut(k, c, r, a, n);
      chk($sformatf("inst%0d match_comb", k), c, 32'(exp_comb(k)));
      chk($sformatf("inst%0d match_reg", k), r, 32'(mreg[k]));
      chk($sformatf("inst%0d armed", k), a, 32'(hist_size(k) >= lens[k] - 1));
      chk($sformatf("inst%0d match_count", k), n, 32'(mcnt[k]));
    end
  endtask

  // One clock: inputs already driven after a negedge; check, clock the model, return after negedge.
  task automatic cycle();
    #1;
    if (!reset_n) model_reset();
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    x = 1'b0; x_valid = 1'b0; load = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    logic [5:0] seq;
    int         exp_sat[6];
    reset_n = 1'b0; overlap = 1'b0; pat3 = '0; pat4 = '0; pat2 = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all();
    reset_n = 1'b1;

    // LEN=3 vectors: non-overlap 110, valid gaps with x toggling, load mid-stream.
    tbl[0]  = mk(1, 0, 0, 0, 'b110, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 'b110, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 'b110, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 'b110, 1, 0, 0, 1);
    tbl[4]  = mk(0, 1, 1, 0, 'b110, 0, 1, 1, 0);
    tbl[5]  = mk(0, 1, 1, 0, 'b110, 0, 0, 1, 0);
    tbl[6]  = mk(0, 1, 0, 0, 'b110, 1, 0, 1, 1);
    tbl[7]  = mk(0, 0, 0, 0, 'b110, 0, 1, 2, 0);
    tbl[8]  = mk(1, 0, 0, 1, 'b110, 0, 0, 2, 0);
    tbl[9]  = mk(0, 1, 1, 0, 'b110, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 'b110, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 1, 0, 'b110, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 'b110, 0, 0, 0, 0);
    tbl[13] = mk(0, 1, 1, 0, 'b110, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 'b110, 0, 0, 0, 1);
    tbl[15] = mk(0, 0, 1, 0, 'b110, 0, 0, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 'b110, 0, 0, 0, 1);
    tbl[17] = mk(0, 1, 0, 0, 'b110, 1, 0, 0, 1);
    tbl[18] = mk(0, 0, 0, 0, 'b110, 0, 1, 1, 0);
    tbl[19] = mk(0, 1, 1, 0, 'b110, 0, 0, 1, 0);
    tbl[20] = mk(0, 1, 1, 0, 'b110, 0, 0, 1, 0);
    tbl[21] = mk(1, 1, 0, 0, 'b011, 0, 0, 1, 1);
    tbl[22] = mk(0, 1, 0, 0, 'b011, 0, 0, 1, 0);
    tbl[23] = mk(0, 1, 1, 0, 'b011, 0, 0, 1, 0);
    tbl[24] = mk(0, 1, 1, 0, 'b011, 1, 0, 1, 1);
    tbl[25] = mk(0, 0, 0, 0, 'b011, 0, 1, 2, 0);
    overlap = 1'b0;
    for (int i = 0; i < 26; i++) begin
      load = tbl[i].ld; x_valid = tbl[i].v; x = tbl[i].xb; cnt_clr = tbl[i].clr;
      pat3 = tbl[i].p; pat4 = 4'(tbl[i].p); pat2 = tbl[i].p[1:0];
      #1;
      chk($sformatf("vec%0d comb", i), 32'(mc_a), 32'(tbl[i].e_comb));
      chk($sformatf("vec%0d reg", i), 32'(mr_a), 32'(tbl[i].e_reg));
      chk($sformatf("vec%0d count", i), 32'(cnt_a), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d armed", i), 32'(arm_a), 32'(tbl[i].e_arm));
      cycle();
    end

    // LEN=4, pattern 1010 on 101010: overlap gives two matches, non-overlap one.
    seq = 6'b101010;
    for (int m = 0; m < 2; m++) begin
      idle_inputs();
      overlap = (m == 0); load = 1'b1; cnt_clr = 1'b1; pat4 = 4'b1010;
      cycle();
      idle_inputs();
      for (int i = 0; i < 6; i++) begin
        x_valid = 1'b1; x = seq[5 - i];
        #1;
        chk($sformatf("len4 ov%0d bit%0d comb", 1 - m, i + 1), 32'(mc_b),
            32'((i == 3) || (m == 0 && i == 5)));
        cycle();
      end
      chk($sformatf("len4 ov%0d count", 1 - m), 32'(cnt_b), (m == 0) ? 32'd2 : 32'd1);
    end

    // LEN=2, CNT_W=2: saturation, then clear colliding with a match.
    idle_inputs();
    overlap = 1'b1; load = 1'b1; cnt_clr = 1'b1; pat2 = 2'b11;
    cycle();
    idle_inputs();
    exp_sat = '{0, 1, 2, 3, 3, 3};
    for (int i = 0; i < 6; i++) begin
      x_valid = 1'b1; x = 1'b1;
      cycle();
      chk($sformatf("sat bit%0d count", i + 1), 32'(cnt_c), 32'(exp_sat[i]));
    end
    cnt_clr = 1'b1;
    #1;
    chk("sat clr comb", 32'(mc_c), 32'd1);
    cycle();
    chk("sat clr count", 32'(cnt_c), 32'd0);
    chk("sat clr reg", 32'(mr_c), 32'd1);

    // Asynchronous reset between edges while armed with a pending registered match.
    idle_inputs();
    overlap = 1'b1; load = 1'b1; cnt_clr = 1'b1; pat3 = 3'b110;
    cycle();
    idle_inputs();
    seq = 6'b000110;
    for (int i = 0; i < 3; i++) begin
      x_valid = 1'b1; x = seq[2 - i];
      cycle();
    end
    chk("pre-reset reg", 32'(mr_a), 32'd1);
    chk("pre-reset count", 32'(cnt_a), 32'd1);
    chk("pre-reset armed", 32'(arm_a), 32'd1);
    idle_inputs();
    reset_n = 1'b0;
    #1;
    chk("async reset reg", 32'(mr_a), 32'd0);
    chk("async reset count", 32'(cnt_a), 32'd0);
    chk("async reset armed", 32'(arm_a), 32'd0);
    chk("async reset comb", 32'(mc_a), 32'd0);
    model_reset();
    cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x_valid = 1'b1; x = 1'b0;
      #1;
      chk($sformatf("post-reset zero%0d comb", i + 1), 32'(mc_a), 32'(i == 2));
      cycle();
    end

    // Randomised traffic against the model on all three instances.
    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      x       = 1'($urandom);
      x_valid = ($urandom_range(0, 3) != 0);
      load    = ($urandom_range(0, 39) == 0);
      cnt_clr = ($urandom_range(0, 99) == 0);
      reset_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 15) == 0) overlap = ~overlap;
      pat3 = 3'($urandom); pat4 = 4'($urandom); pat2 = 2'($urandom);
      cycle();
    end
    reset_n = 1'b1;
    idle_inputs();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
